silife_spi_master_ng: RTL and testbench
=======================================

Name: silife_spi_master_ng

Overview:
- Parametrised, full-duplex SPI master for on-chip configuration and readback traffic.
- Configurable word width and chip-select count. Runtime-selectable SPI mode (CPOL/CPHA), bit order and SCK divider.
- Captures MISO into a read word, and can hold CS asserted across consecutive words for multi-word frames.
- Sits between the control FSM (start/busy/done handshake) and the chip pads.

Parameters:
WIDTH, 16, bits per transfer (>=2)
NUM_CS, 1, number of chip-select outputs (>=1)
DIV_WIDTH, 8, width of runtime half-period divider
CS_IDX_W, $clog2(NUM_CS) or 1 if NUM_CS==1, width of CS index

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_word  in  WIDTH  transmit word
i_start  in  1  start request, accepted only when o_busy=0
i_cs_index  in  CS_IDX_W  chip select to drive; values >= NUM_CS select no line (transfer still runs)
i_cpol  in  1  SCK idle level
i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
i_lsb_first  in  1  0: MSB first; 1: LSB first
i_half_div  in  DIV_WIDTH  SCK half-period in clk cycles; 0 treated as 1
i_hold_cs  in  1  keep CS asserted after this word
i_miso  in  1  serial data in; externally synchronised
o_sck  out  1  serial clock
o_mosi  out  1  serial data out
o_cs_n  out  NUM_CS  active-low chip selects
o_busy  out  1  transfer in progress
o_done  out  1  one-cycle completion pulse
o_rdata  out  WIDTH  last received word

Behaviour:
- Reset values: o_sck=0, o_mosi=0, o_cs_n all 1, o_busy=0, o_done=0, o_rdata=0, FSM=IDLE, no CS held. A reset mid-transfer aborts immediately; no o_done is generated.
- Interface is "already decided": reset reset, synchronous, active-high; clock clk.
- All config inputs and i_word are latched on the accept edge; later changes are ignored until the next accept.
- Let D = max(i_half_div,1).
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE. Each phase of SETUP/HOLD and each SCK half-period lasts exactly D cycles.
- Accept: i_start=1 and o_busy=0 at a clk edge. On that edge:
  - o_busy<=1 and o_cs_n[idx]<=0.
  - Any other held CS deasserts.
  - o_sck<=latched CPOL.
  - If CPHA=0, o_mosi<=first bit.
- SETUP: D cycles with SCK idle, then enter SHIFT.
- SHIFT: 2*WIDTH half-periods; o_sck toggles at the start of each.
  - CPHA=0: MISO sampled on leading (odd) edges. MOSI advances on trailing edges, except after the last bit.
  - CPHA=1: MOSI updated on leading edges. MISO sampled on trailing edges.
  - Ends with o_sck at CPOL.
- HOLD: D cycles, then:
  - o_busy<=0 and o_done<=1 for one cycle.
  - o_rdata updated on that same edge.
  - o_cs_n[idx]<=1 unless latched hold_cs=1.
- o_busy is high for exactly (2*WIDTH+2)*D cycles.
- Bit order: MSB-first sends i_word[WIDTH-1] first and places the first received bit at o_rdata[WIDTH-1]. LSB-first mirrors this.
- o_rdata is stable between done pulses.
- Back-to-back: i_start in the o_done cycle is accepted (o_busy=0). If the CS was held and the index is unchanged, CS stays low continuously.
- Held CS release: only by reset, or by a later transfer completing with hold_cs=0 or selecting a different index.
- Idle SCK: with o_busy=0, o_sck<=i_cpol each cycle (1-cycle latency). Exception: while a CS is held, SCK keeps the latched CPOL.
- i_start while busy is ignored; no queuing.
- o_mosi holds its last value when idle.
- Divider and bit counters must not wrap or overflow for DIV_WIDTH and WIDTH at their maxima.

Test Plan:
- Mode 0, WIDTH=16, D=2, word 0xA5C3, MISO looped to MOSI, NUM_CS=2, idx=1:
  - o_cs_n=2'b01 during transfer.
  - 16 rising SCK edges.
  - o_busy high 68 cycles.
  - o_done 1 cycle.
  - o_rdata=0xA5C3.
- Mode 3, LSB-first, D=3, word 0x0001, MISO tied 1:
  - SCK idles high.
  - First MOSI bit 1, then 15 zeros.
  - o_rdata=0xFFFF.
  - busy 102 cycles.
- i_half_div=0 vs 1: identical waveforms; busy 34 cycles for WIDTH=16.
- Hold CS:
  - Word 0x1234 with hold=1, then start in the done cycle with 0x5678, hold=0.
  - CS low continuously across both words, high after the second done.
  - Two done pulses.
- Start while busy: a second i_start at cycle 10 is ignored; exactly one done.
- Reset at cycle 20 of a transfer: next edge gives o_cs_n all 1, o_sck=0, o_busy=0, no o_done. A subsequent transfer completes normally.

Source files
------------

// File: rtl/silife_spi_master_ng_if.sv
// rtl/silife_spi_master_ng_if.sv - Control-side handshake bundle between the control FSM and the SPI master
interface silife_spi_master_ng_if #(
   parameter int WIDTH     = 16,
   parameter int NUM_CS    = 1,
   parameter int DIV_WIDTH = 8,
   parameter int CS_IDX_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
   logic [WIDTH-1:0]     i_word;
   logic                 i_start;
   logic [CS_IDX_W-1:0]  i_cs_index;
   logic                 i_cpol;
   logic                 i_cpha;
   logic                 i_lsb_first;
   logic [DIV_WIDTH-1:0] i_half_div;
   logic                 i_hold_cs;
   logic                 o_busy;
   logic                 o_done;
   logic [WIDTH-1:0]     o_rdata;

   modport master (
      output i_word, i_start, i_cs_index, i_cpol, i_cpha, i_lsb_first, i_half_div, i_hold_cs,
      input  o_busy, o_done, o_rdata
   );

   modport slave (
      input  i_word, i_start, i_cs_index, i_cpol, i_cpha, i_lsb_first, i_half_div, i_hold_cs,
      output o_busy, o_done, o_rdata
   );
endinterface

// File: rtl/silife_spi_master_ng.sv
// rtl/silife_spi_master_ng.sv - Full-duplex SPI master with runtime CPOL/CPHA, bit order, divider and CS hold
module silife_spi_master_ng #(
   parameter int WIDTH     = 16,
   parameter int NUM_CS    = 1,
   parameter int DIV_WIDTH = 8,
   parameter int CS_IDX_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   silife_spi_master_ng_if.slave ctrl,
   input  logic                  i_miso,
   output logic                  o_sck,
   output logic                  o_mosi,
   output logic [NUM_CS-1:0]     o_cs_n
);
   localparam int HP_W = $clog2(2 * WIDTH + 1);
   localparam logic [HP_W-1:0] HP_LAST     = HP_W'(2 * WIDTH);
   localparam logic [HP_W-1:0] HP_LAST_BIT = HP_W'(2 * WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] div_q, div_d, d_q, d_d;
   logic [HP_W-1:0]      hp_q, hp_d;
   logic [WIDTH-1:0]     tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
   logic                 cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
   logic                 hold_q, hold_d, valid_q, valid_d, held_q, held_d;
   logic                 sck_q, sck_d, mosi_q, mosi_d, done_q, done_d;
   logic [NUM_CS-1:0]    cs_n_q, cs_n_d;
   logic                 phase_end, edge_en, leading, sample, shift_out, sel_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         d_q     <= DIV_WIDTH'(1);
         hp_q    <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
         hold_q  <= 1'b0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_n_q  <= '1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         d_q     <= d_d;
         hp_q    <= hp_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         lsb_q   <= lsb_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
         held_q  <= held_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
         cs_n_q  <= cs_n_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      d_d       = d_q;
      hp_d      = hp_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rdata_d   = rdata_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      lsb_d     = lsb_q;
      hold_d    = hold_q;
      valid_d   = valid_q;
      held_d    = held_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      done_d    = 1'b0;
      cs_n_d    = cs_n_q;
      edge_en   = 1'b0;
      leading   = 1'b0;
      sample    = 1'b0;
      shift_out = 1'b0;
      sel_valid = 32'(ctrl.i_cs_index) < 32'(NUM_CS);
      phase_end = (div_q == d_q - DIV_WIDTH'(1));

      case (state_q)
         IDLE: begin
            // A held CS pins SCK to the polarity its frame was started with
            if (!held_q) sck_d = ctrl.i_cpol;
            if (ctrl.i_start) begin
               state_d = SETUP;
               div_d   = '0;
               hp_d    = '0;
               rx_d    = '0;
               d_d     = (ctrl.i_half_div == '0) ? DIV_WIDTH'(1) : ctrl.i_half_div;
               cpol_d  = ctrl.i_cpol;
               cpha_d  = ctrl.i_cpha;
               lsb_d   = ctrl.i_lsb_first;
               hold_d  = ctrl.i_hold_cs;
               valid_d = sel_valid;
               sck_d   = ctrl.i_cpol;
               for (int i = 0; i < NUM_CS; i++)
                  cs_n_d[i] = !(sel_valid && (32'(ctrl.i_cs_index) == 32'(i)));
               if (!ctrl.i_cpha) begin
                  mosi_d = ctrl.i_lsb_first ? ctrl.i_word[0] : ctrl.i_word[WIDTH-1];
                  tx_d   = ctrl.i_lsb_first ? {1'b0, ctrl.i_word[WIDTH-1:1]}
                                            : {ctrl.i_word[WIDTH-2:0], 1'b0};
               end else begin
                  tx_d = ctrl.i_word;
               end
            end
         end
         SETUP: begin
            if (phase_end) begin
               div_d   = '0;
               edge_en = 1'b1;
               state_d = SHIFT;
            end else begin
               div_d = div_q + DIV_WIDTH'(1);
            end
         end
         SHIFT: begin
            if (phase_end) begin
               div_d = '0;
               if (hp_q == HP_LAST) state_d = HOLD;
               else                 edge_en = 1'b1;
            end else begin
               div_d = div_q + DIV_WIDTH'(1);
            end
         end
         HOLD: begin
            if (phase_end) begin
               div_d   = '0;
               state_d = IDLE;
               done_d  = 1'b1;
               rdata_d = rx_q;
               held_d  = hold_q && valid_q;
               if (!hold_q) cs_n_d = '1;
            end else begin
               div_d = div_q + DIV_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // hp_q counts SCK edges already made, so an even count means this edge is a leading one
      if (edge_en) begin
         sck_d     = ~sck_q;
         hp_d      = hp_q + HP_W'(1);
         leading   = !hp_q[0];
         sample    = cpha_q ? !leading : leading;
         shift_out = cpha_q ? leading : (!leading && (hp_q != HP_LAST_BIT));
         if (sample)
            rx_d = lsb_q ? {i_miso, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], i_miso};
         if (shift_out) begin
            mosi_d = lsb_q ? tx_q[0] : tx_q[WIDTH-1];
            tx_d   = lsb_q ? {1'b0, tx_q[WIDTH-1:1]} : {tx_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign o_sck        = sck_q;
   assign o_mosi       = mosi_q;
   assign o_cs_n       = cs_n_q;
   assign ctrl.o_busy  = (state_q != IDLE);
   assign ctrl.o_done  = done_q;
   assign ctrl.o_rdata = rdata_q;
endmodule

// File: tb/tb_silife_spi_master_ng.sv
// tb/tb_silife_spi_master_ng.sv - Scoreboard bench for silife_spi_master_ng (WIDTH=16, NUM_CS=2)
module tb_silife_spi_master_ng;
   localparam int WIDTH     = 16;
   localparam int NUM_CS    = 2;
   localparam int DIV_WIDTH = 8;
   localparam int CS_IDX_W  = 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              i_miso, o_sck, o_mosi;
   logic [NUM_CS-1:0] o_cs_n;
   logic [1:0]        miso_sel;

   int tests = 0, fails = 0;
   int busy_cnt, done_cnt, rise_cnt;
   logic prev_sck, sck_fell;
   logic [WIDTH-1:0] exp_q[$];

   always #5 clk = ~clk;

   silife_spi_master_ng_if #(.WIDTH(WIDTH), .NUM_CS(NUM_CS), .DIV_WIDTH(DIV_WIDTH),
                             .CS_IDX_W(CS_IDX_W)) bus ();

   assign i_miso = (miso_sel == 2'd0) ? o_mosi : (miso_sel == 2'd1);

   silife_spi_master_ng #(.WIDTH(WIDTH), .NUM_CS(NUM_CS), .DIV_WIDTH(DIV_WIDTH),
                          .CS_IDX_W(CS_IDX_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .ctrl   (bus),
      .i_miso (i_miso),
      .o_sck  (o_sck),
      .o_mosi (o_mosi),
      .o_cs_n (o_cs_n)
   );

   task automatic step();
      @(posedge clk);
      #1;
      if (bus.o_busy) busy_cnt++;
      if (bus.o_done) done_cnt++;
      if (o_sck && !prev_sck) rise_cnt++;
      sck_fell = prev_sck && !o_sck;
      prev_sck = o_sck;
   endtask

   task automatic drive(input logic [WIDTH-1:0] word, input logic [0:0] idx, input logic cpol,
                        input logic cpha, input logic lsb, input logic [7:0] div, input logic hold);
      bus.i_word      = word;
      bus.i_cs_index  = idx;
      bus.i_cpol      = cpol;
      bus.i_cpha      = cpha;
      bus.i_lsb_first = lsb;
      bus.i_half_div  = div;
      bus.i_hold_cs   = hold;
   endtask

   task automatic start();
      busy_cnt = 0;
      done_cnt = 0;
      rise_cnt = 0;
      prev_sck = o_sck;
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.i_start = 1'b0;
      miso_sel = 2'd0;
      drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
      repeat (3) step();
      tests++; if (o_sck !== 1'b0) begin fails++; $display("FAIL reset_sck got=%b exp=0", o_sck); end
      tests++; if (o_mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi got=%b exp=0", o_mosi); end
      tests++; if (o_cs_n !== 2'b11) begin fails++; $display("FAIL reset_cs_n got=%b exp=11", o_cs_n); end
      tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
      tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.o_done); end
      tests++; if (bus.o_rdata !== 16'h0000) begin fails++; $display("FAIL reset_rdata got=%h exp=0000", bus.o_rdata); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_mode0();
      int n = 0, cs_bad = 0;
      logic [WIDTH-1:0] e;
      miso_sel = 2'd0;
      drive(16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
      repeat (2) step();
      exp_q.push_back(16'hA5C3);
      start();
      while (!bus.o_done && n < 500) begin
         if (bus.o_busy && o_cs_n !== 2'b01) cs_bad++;
         step();
         n++;
      end
      tests++;
      if (!bus.o_done) begin fails++; $display("FAIL m0_timeout got=no_done exp=done"); exp_q.delete(); end
      else begin
         e = exp_q.pop_front();
         if (bus.o_rdata !== e) begin fails++; $display("FAIL m0_rdata got=%h exp=%h", bus.o_rdata, e); end
      end
      repeat (4) step();
      tests++; if (busy_cnt != 68) begin fails++; $display("FAIL m0_busy got=%0d exp=68", busy_cnt); end
      tests++; if (rise_cnt != 16) begin fails++; $display("FAIL m0_rises got=%0d exp=16", rise_cnt); end
      tests++; if (done_cnt != 1) begin fails++; $display("FAIL m0_done_cnt got=%0d exp=1", done_cnt); end
      tests++; if (cs_bad != 0) begin fails++; $display("FAIL m0_cs_n got=%0d_bad_cycles exp=0", cs_bad); end
      tests++; if (o_cs_n !== 2'b11) begin fails++; $display("FAIL m0_cs_release got=%b exp=11", o_cs_n); end
   endtask

   task automatic test_mode3_lsb();
      int n = 0, k = 0;
      logic [WIDTH-1:0] bits = '0;
      logic [WIDTH-1:0] e;
      miso_sel = 2'd1;
      drive(16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0);
      repeat (2) step();
      tests++; if (o_sck !== 1'b1) begin fails++; $display("FAIL m3_idle_sck got=%b exp=1", o_sck); end
      exp_q.push_back(16'hFFFF);
      start();
      while (!bus.o_done && n < 500) begin
         if (bus.o_busy && o_cs_n !== 2'b10) k += 100;
         step();
         if (sck_fell && k < WIDTH) begin bits[k] = o_mosi; k++; end
         n++;
      end
      tests++;
      if (!bus.o_done) begin fails++; $display("FAIL m3_timeout got=no_done exp=done"); exp_q.delete(); end
      else begin
         e = exp_q.pop_front();
         if (bus.o_rdata !== e) begin fails++; $display("FAIL m3_rdata got=%h exp=%h", bus.o_rdata, e); end
      end
      tests++; if (k != WIDTH) begin fails++; $display("FAIL m3_edges got=%0d exp=16", k); end
      tests++; if (bits !== 16'h0001) begin fails++; $display("FAIL m3_mosi_bits got=%h exp=0001", bits); end
      tests++; if (busy_cnt != 102) begin fails++; $display("FAIL m3_busy got=%0d exp=102", busy_cnt); end
      tests++; if (o_sck !== 1'b1) begin fails++; $display("FAIL m3_end_sck got=%b exp=1", o_sck); end
   endtask

   task automatic test_div0();
      logic [3:0] tr0 [64];
      logic [3:0] tr1 [64];
      int busy0 = 0, diff = 0;
      logic [WIDTH-1:0] e;
      miso_sel = 2'd0;
      for (int p = 0; p < 2; p++) begin
         int n = 0;
         drive(16'h3C5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'(p), 1'b0);
         repeat (2) step();
         exp_q.push_back(16'h3C5A);
         start();
         while (!bus.o_done && n < 200) begin
            if (n < 64) begin
               if (p == 0) tr0[n] = {o_sck, o_mosi, o_cs_n};
               else        tr1[n] = {o_sck, o_mosi, o_cs_n};
            end
            step();
            n++;
         end
         tests++;
         if (!bus.o_done) begin fails++; $display("FAIL div%0d_timeout got=no_done exp=done", p); exp_q.delete(); end
         else begin
            e = exp_q.pop_front();
            if (bus.o_rdata !== e) begin fails++; $display("FAIL div%0d_rdata got=%h exp=%h", p, bus.o_rdata, e); end
         end
         tests++;
         if (busy_cnt != 34) begin fails++; $display("FAIL div%0d_busy got=%0d exp=34", p, busy_cnt); end
         if (p == 0) busy0 = busy_cnt;
         step();
      end
      for (int i = 0; i < 34; i++) if (tr0[i] !== tr1[i]) diff++;
      tests++; if (diff != 0) begin fails++; $display("FAIL div_wave got=%0d_diffs exp=0 (busy0=%0d)", diff, busy0); end
   endtask

   task automatic test_hold_cs();
      int n = 0, cs_bad = 0;
      logic [WIDTH-1:0] e;
      miso_sel = 2'd0;
      drive(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);
      repeat (2) step();
      exp_q.push_back(16'h1234);
      exp_q.push_back(16'h5678);
      start();
      while (!bus.o_done && n < 500) begin
         if (o_cs_n[0] !== 1'b0) cs_bad++;
         step();
         n++;
      end
      if (o_cs_n[0] !== 1'b0) cs_bad++;
      tests++;
      if (!bus.o_done) begin fails++; $display("FAIL hold_first_timeout got=no_done exp=done"); end
      else begin
         e = exp_q.pop_front();
         if (bus.o_rdata !== e) begin fails++; $display("FAIL hold_first_rdata got=%h exp=%h", bus.o_rdata, e); end
      end
      drive(16'h5678, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
      n = 0;
      while (!bus.o_done && n < 500) begin
         if (o_cs_n[0] !== 1'b0) cs_bad++;
         step();
         n++;
      end
      tests++;
      if (!bus.o_done) begin fails++; $display("FAIL hold_second_timeout got=no_done exp=done"); exp_q.delete(); end
      else begin
         e = exp_q.pop_front();
         if (bus.o_rdata !== e) begin fails++; $display("FAIL hold_second_rdata got=%h exp=%h", bus.o_rdata, e); end
      end
      tests++; if (o_cs_n !== 2'b11) begin fails++; $display("FAIL hold_release got=%b exp=11", o_cs_n); end
      repeat (4) step();
      tests++; if (cs_bad != 0) begin fails++; $display("FAIL hold_cs_low got=%0d_bad_cycles exp=0", cs_bad); end
      tests++; if (done_cnt != 2) begin fails++; $display("FAIL hold_done_cnt got=%0d exp=2", done_cnt); end
   endtask

   task automatic test_start_busy();
      int n = 0;
      logic [WIDTH-1:0] e;
      miso_sel = 2'd0;
      drive(16'hC0DE, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
      repeat (2) step();
      exp_q.push_back(16'hC0DE);
      start();
      repeat (8) step();
      drive(16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0);
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
      while (!bus.o_done && n < 500) begin step(); n++; end
      tests++;
      if (!bus.o_done) begin fails++; $display("FAIL busy_timeout got=no_done exp=done"); exp_q.delete(); end
      else begin
         e = exp_q.pop_front();
         if (bus.o_rdata !== e) begin fails++; $display("FAIL busy_rdata got=%h exp=%h", bus.o_rdata, e); end
      end
      repeat (80) step();
      tests++; if (done_cnt != 1) begin fails++; $display("FAIL busy_done_cnt got=%0d exp=1", done_cnt); end
      tests++; if (busy_cnt != 68) begin fails++; $display("FAIL busy_cycles got=%0d exp=68", busy_cnt); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      logic [WIDTH-1:0] e;
      miso_sel = 2'd0;
      drive(16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
      repeat (2) step();
      start();
      repeat (18) step();
      reset = 1'b1;
      step();
      tests++; if (o_cs_n !== 2'b11) begin fails++; $display("FAIL rst_cs_n got=%b exp=11", o_cs_n); end
      tests++; if (o_sck !== 1'b0) begin fails++; $display("FAIL rst_sck got=%b exp=0", o_sck); end
      tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", bus.o_busy); end
      reset = 1'b0;
      repeat (80) step();
      tests++; if (done_cnt != 0) begin fails++; $display("FAIL rst_no_done got=%0d exp=0", done_cnt); end
      drive(16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
      exp_q.push_back(16'h0F0F);
      start();
      while (!bus.o_done && n < 500) begin step(); n++; end
      tests++;
      if (!bus.o_done) begin fails++; $display("FAIL rst_after_timeout got=no_done exp=done"); exp_q.delete(); end
      else begin
         e = exp_q.pop_front();
         if (bus.o_rdata !== e) begin fails++; $display("FAIL rst_after_rdata got=%h exp=%h", bus.o_rdata, e); end
      end
      tests++; if (busy_cnt != 68) begin fails++; $display("FAIL rst_after_busy got=%0d exp=68", busy_cnt); end
   endtask

   initial begin
      prev_sck = 1'b0;
      sck_fell = 1'b0;
      busy_cnt = 0;
      done_cnt = 0;
      rise_cnt = 0;
      test_reset();
      test_mode0();
      test_mode3_lsb();
      test_div0();
      test_hold_cs();
      test_start_busy();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
